covar_estimator: RTL
====================

// Module: covar_estimator
// PURPOSE
//  Producer side of the uncertainty-propagation datapath: estimates var_x, var_y and covar_xy
//  from a stream of paired signed samples (x,y) over a block of N samples. Emits one 16-bit
//  result triple per block, in the exact format the propagation block consumes.
//  Uses one shared 16x16 signed multiplier (one iCE40 DSP), time-multiplexed by an FSM.
// PARAMETERS
//  LOG2N   2   block length N = 2**LOG2N samples; legal range 1..8
//  SW      16  sample width (x, y); fixed at 16 for this revision
// PORTS
//  clk        in   1   system clock (48 MHz from SB_HFOSC)
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   sample pair valid
//  in_ready   out  1   block can accept a sample this cycle
//  x          in   16  sample x, two's complement
//  y          in   16  sample y, two's complement
//  out_valid  out  1   result triple valid; held until accepted
//  out_ready  in   1   downstream accepts result
//  var_x      out  16  variance of x, unsigned, saturated
//  var_y      out  16  variance of y, unsigned, saturated
//  covar_xy   out  16  covariance, two's complement, saturated
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM->S_IDLE; sample count, all accumulators, var_x, var_y,
//   covar_xy and out_valid = 0; in_ready = 1 from the first clk edge after rst_n rises.
//  Transfer rule: sample taken when in_valid & in_ready at posedge clk; result taken when
//   out_valid & out_ready. in_ready is registered and is 1 only in S_IDLE.
//  Accumulators (signed): sx, sy on 16+LOG2N bits; sxx, syy, sxy on 32+LOG2N bits.
//  FSM, per accepted sample (x, y latched):
//   S_IDLE -> S_XX (sxx += x*x) -> S_YY (syy += y*y) -> S_XY (sxy += x*y; cnt++).
//   sx += x and sy += y in the capture cycle. Sample throughput: 1 per 4 cycles.
//   After S_XY: if cnt == N -> S_MEAN, else -> S_IDLE.
//  Finalize: S_MEAN computes mx = sx>>>LOG2N and my = sy>>>LOG2N (arithmetic shift, i.e.
//   floor). Then S_FXX, S_FYY, S_FXY, one multiplier product each:
//   var_x = (sxx>>>LOG2N) - mx*mx;  var_y = (syy>>>LOG2N) - my*my;
//   covar_xy = (sxy>>>LOG2N) - mx*my.  Differences are computed at full width.
//  Saturation: var_x and var_y clamp to [0, 16'hFFFF]; a negative value is a floor artefact
//   and clamps to 0. covar_xy clamps to [-32768, 32767].
//  S_OUT: out_valid = 1 and outputs stable until out_ready. On the handshake: accumulators
//   and cnt cleared, out_valid = 0, -> S_IDLE. Outputs keep the last values until the
//   next S_OUT.
//  Latency: last sample accept -> out_valid = 3 (MAC) + 1 (MEAN) + 3 (FIN) + 1 = 8 cycles.
//  Backpressure: no sample is accepted from the block's Nth sample until the result is taken.
//  in_valid with in_ready=0 is ignored; x and y are not sampled.
//  Reset mid-block or mid-finalize: the partial block is discarded and no out_valid is issued.
//  Multiplier: 16x16 signed -> 32 registered-free (combinational DSP mode); both operand
//   muxes are driven by FSM state only.
// STRUCTURE
//  Package covar_pkg: state encodings (S_IDLE, S_XX, S_YY, S_XY, S_MEAN, S_FXX, S_FYY,
//   S_FXY, S_OUT); localparams ACC1_W = 16+LOG2N, ACC2_W = 32+LOG2N; sat16u and sat16s
//   functions.
//  Sub-module dsp_mul16s (A, B -> O): single signed 16x16 multiply on one SB_MAC16, shared
//   by all MAC and finalize steps. Everything else is in the top: FSM, accumulators,
//   saturation.
// TESTING (LOG2N=2, N=4)
//  1 x = 5,5,5,5 ; y = -3,-3,-3,-3 -> var_x = 0, var_y = 0, covar_xy = 0, 8 cycles after
//    the 4th accept.
//  2 x = 2,-2,2,-2 ; y = x -> var_x = 4, var_y = 4, covar_xy = 4. Repeat with y = -x ->
//    covar_xy = -4 (16'hFFFC).
//  3 x = 1,2,3,4 ; y = 4,3,2,1 -> var_x = 3, var_y = 3, covar_xy = 1 (floor-mean
//    arithmetic, bit-exact).
//  4 x = 32767,-32768 alternating ; y = x -> var_x = var_y = 16'hFFFF,
//    covar_xy = 16'h7FFF (saturated).
//  5 out_ready held 0 for 20 cycles after out_valid -> outputs stable, in_ready = 0,
//    in_valid pulses ignored; then one cycle out_ready = 1 -> next block accepted fresh.
//  6 rst_n asserted after 2 samples, or during S_FXX -> all outputs 0 immediately; a new
//    4-sample block then gives correct results with no residue.

Source files
------------

// File: rtl/covar_pkg.sv
// rtl/covar_pkg.sv - shared states, widths and saturation helpers for covar_estimator
package covar_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_XX,
    S_YY,
    S_XY,
    S_MEAN,
    S_FXX,
    S_FYY,
    S_FXY,
    S_OUT
  } state_e;

  // Finalize differences are formed at this width; it covers ACC2_W for LOG2N up to 8.
  localparam int DIFF_W = 48;

  function automatic logic [15:0] sat16u(input logic signed [DIFF_W-1:0] v);
    if (v < 0) begin
      return 16'h0000;
    end else if (v > 48'sd65535) begin
      return 16'hFFFF;
    end else begin
      return v[15:0];
    end
  endfunction

  function automatic logic [15:0] sat16s(input logic signed [DIFF_W-1:0] v);
    if (v < -48'sd32768) begin
      return 16'h8000;
    end else if (v > 48'sd32767) begin
      return 16'h7FFF;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/dsp_mul16s.sv
// rtl/dsp_mul16s.sv - combinational signed 16x16 multiply, maps to one SB_MAC16
module dsp_mul16s (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [31:0] o
);

  assign o = a * b;

endmodule

// File: rtl/covar_estimator.sv
// rtl/covar_estimator.sv - block variance/covariance estimator
// One shared multiplier is stepped through MAC and finalize states by the FSM.
module covar_estimator
  import covar_pkg::*;
#(
  parameter int LOG2N = 2,
  parameter int SW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] x,
  input  logic [SW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   var_x,
  output logic [15:0]   var_y,
  output logic [15:0]   covar_xy
);

  localparam int ACC1_W = 16 + LOG2N;
  localparam int ACC2_W = 32 + LOG2N;

  state_e                     state_q, state_d;
  logic [LOG2N:0]             cnt_q, cnt_d;
  logic signed [15:0]         x_q, x_d, y_q, y_d;
  logic signed [ACC1_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic signed [ACC2_W-1:0]   sxx_q, sxx_d, syy_q, syy_d, sxy_q, sxy_d;
  logic signed [15:0]         mx_q, mx_d, my_q, my_d;
  logic [15:0]                res_x_q, res_x_d, res_y_q, res_y_d, res_xy_q, res_xy_d;
  logic [15:0]                var_x_q, var_x_d, var_y_q, var_y_d, covar_xy_q, covar_xy_d;
  logic                       out_valid_q, out_valid_d;
  logic                       in_ready_q, in_ready_d;

  logic signed [15:0]         mul_a, mul_b;
  logic signed [31:0]         prod;
  logic signed [ACC2_W-1:0]   fin_acc;
  logic signed [DIFF_W-1:0]   fin_diff;

  dsp_mul16s u_mul (
    .a (mul_a),
    .b (mul_b),
    .o (prod)
  );

  // Operand muxes depend on state only, so the DSP sees no handshake-dependent paths.
  always_comb begin
    mul_a   = '0;
    mul_b   = '0;
    fin_acc = sxy_q;
    case (state_q)
      S_XX:    begin mul_a = x_q;  mul_b = x_q; end
      S_YY:    begin mul_a = y_q;  mul_b = y_q; end
      S_XY:    begin mul_a = x_q;  mul_b = y_q; end
      S_FXX:   begin mul_a = mx_q; mul_b = mx_q; fin_acc = sxx_q; end
      S_FYY:   begin mul_a = my_q; mul_b = my_q; fin_acc = syy_q; end
      S_FXY:   begin mul_a = mx_q; mul_b = my_q; fin_acc = sxy_q; end
      default: begin mul_a = '0;   mul_b = '0; end
    endcase
    fin_diff = DIFF_W'(fin_acc >>> LOG2N) - DIFF_W'(prod);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    sxx_d       = sxx_q;
    syy_d       = syy_q;
    sxy_d       = sxy_q;
    mx_d        = mx_q;
    my_d        = my_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_xy_d    = res_xy_q;
    var_x_d     = var_x_q;
    var_y_d     = var_y_q;
    covar_xy_d  = covar_xy_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d     = $signed(x);
          y_d     = $signed(y);
          sx_d    = sx_q + ACC1_W'($signed(x));
          sy_d    = sy_q + ACC1_W'($signed(y));
          state_d = S_XX;
        end
      end
      S_XX: begin
        sxx_d   = sxx_q + ACC2_W'(prod);
        state_d = S_YY;
      end
      S_YY: begin
        syy_d   = syy_q + ACC2_W'(prod);
        state_d = S_XY;
      end
      S_XY: begin
        sxy_d   = sxy_q + ACC2_W'(prod);
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == (LOG2N+1)'((1 << LOG2N) - 1)) ? S_MEAN : S_IDLE;
      end
      S_MEAN: begin
        mx_d    = 16'(sx_q >>> LOG2N);
        my_d    = 16'(sy_q >>> LOG2N);
        state_d = S_FXX;
      end
      S_FXX: begin
        res_x_d = sat16u(fin_diff);
        state_d = S_FYY;
      end
      S_FYY: begin
        res_y_d = sat16u(fin_diff);
        state_d = S_FXY;
      end
      S_FXY: begin
        res_xy_d = sat16s(fin_diff);
        state_d  = S_OUT;
      end
      S_OUT: begin
        // First S_OUT cycle publishes the results; outputs only change here.
        if (!out_valid_q) begin
          var_x_d     = res_x_q;
          var_y_d     = res_y_q;
          covar_xy_d  = res_xy_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          sx_d        = '0;
          sy_d        = '0;
          sxx_d       = '0;
          syy_d       = '0;
          sxy_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      sxx_q       <= '0;
      syy_q       <= '0;
      sxy_q       <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_xy_q    <= '0;
      var_x_q     <= '0;
      var_y_q     <= '0;
      covar_xy_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sxx_q       <= sxx_d;
      syy_q       <= syy_d;
      sxy_q       <= sxy_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_xy_q    <= res_xy_d;
      var_x_q     <= var_x_d;
      var_y_q     <= var_y_d;
      covar_xy_q  <= covar_xy_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign var_x     = var_x_q;
  assign var_y     = var_y_q;
  assign covar_xy  = covar_xy_q;

endmodule
